// File: rtl/alu_cmd_sequencer_if.sv
// ============================================================================
// Module      : alu_cmd_sequencer_if
// Description : Request, ALU drive and response bundle for alu_cmd_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_cmd_sequencer_if #(
    parameter int OP_W  = 8,
    parameter int CMD_W = 4,
    parameter int RES_W = 16,
    parameter int DEPTH = 4
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic               req_valid;
    logic               req_ready;
    logic [OP_W-1:0]    req_op1;
    logic [OP_W-1:0]    req_op2;
    logic [CMD_W-1:0]   req_cmd;
    logic [OP_W-1:0]    alu_operand_1;
    logic [OP_W-1:0]    alu_operand_2;
    logic [CMD_W-1:0]   alu_command;
    logic               alu_en;
    logic [RES_W-1:0]   alu_out;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [RES_W-1:0]   rsp_data;
    logic [CMD_W-1:0]   rsp_cmd;
    logic               busy;
    logic [c_CNT_W-1:0] fifo_count;

    // Environment side: host, consumer and the ALU itself
    modport master (
        output req_valid, req_op1, req_op2, req_cmd, rsp_ready, alu_out,
        input  req_ready, alu_operand_1, alu_operand_2, alu_command, alu_en,
               rsp_valid, rsp_data, rsp_cmd, busy, fifo_count
    );

    modport slave (
        input  req_valid, req_op1, req_op2, req_cmd, rsp_ready, alu_out,
        output req_ready, alu_operand_1, alu_operand_2, alu_command, alu_en,
               rsp_valid, rsp_data, rsp_cmd, busy, fifo_count
    );
endinterface

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Drives a combinational ALU for SETTLE cycles per request and
//               queues captured results in a fall-through FIFO.
//               Optional macro ALU_SEQ_DONE_COUNT_EN adds a done_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
    parameter int OP_W   = 8,
    parameter int CMD_W  = 4,
    parameter int RES_W  = 16,
    parameter int SETTLE = 2,
    parameter int DEPTH  = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    alu_cmd_sequencer_if.slave     bus
`ifdef ALU_SEQ_DONE_COUNT_EN
    ,
    output logic [15:0]            done_count
`endif
);
    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [3:0]         c_SETTLE_LD = 4'(SETTLE - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_settle;
    logic [OP_W-1:0]    r_op1;
    logic [OP_W-1:0]    r_op2;
    logic [CMD_W-1:0]   r_cmd;
    logic [RES_W-1:0]   r_mem_res [DEPTH];
    logic [CMD_W-1:0]   r_mem_cmd [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_space;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_req_ready;
    logic w_busy;
    logic w_not_empty;

    assign w_space     = (r_count < c_DEPTH_CNT);
    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_not_empty && bus.rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = w_space;
                w_accept    = bus.req_valid && w_space;
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_busy = 1'b1;
                if (r_settle == 4'd0) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand/command registers only change on acceptance, so they stay
    // stable through EXEC and hold their last value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_cmd    <= '0;
            r_settle <= 4'd0;
        end else if (w_accept) begin
            r_op1    <= bus.req_op1;
            r_op2    <= bus.req_op2;
            r_cmd    <= bus.req_cmd;
            r_settle <= c_SETTLE_LD;
        end else if (w_busy && (r_settle != 4'd0)) begin
            r_settle <= r_settle - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_res[r_wr_ptr] <= bus.alu_out;
            r_mem_cmd[r_wr_ptr] <= r_cmd;
        end
    end

    // Space is reserved at acceptance, so a push never finds the FIFO full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ALU_SEQ_DONE_COUNT_EN
    logic [15:0] r_done_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_count <= 16'd0;
        end else if (w_push) begin
            r_done_count <= r_done_count + 16'd1;
        end
    end

    assign done_count = r_done_count;
`endif

    assign bus.req_ready     = w_req_ready;
    assign bus.busy          = w_busy;
    assign bus.alu_en        = w_busy;
    assign bus.alu_operand_1 = r_op1;
    assign bus.alu_operand_2 = r_op2;
    assign bus.alu_command   = r_cmd;
    assign bus.rsp_valid     = w_not_empty;
    assign bus.rsp_data      = w_not_empty ? r_mem_res[r_rd_ptr] : '0;
    assign bus.rsp_cmd       = w_not_empty ? r_mem_cmd[r_rd_ptr] : '0;
    assign bus.fifo_count    = r_count;

endmodule

`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator-side driver for the 8-bit-operand / 4-bit-command / 16-bit-result ALU interface. It accepts operand+command requests on a valid/ready port, drives the ALU inputs and enable, waits a fixed settle time, and captures the ALU result. Captured results go into a small result FIFO with a valid/ready response port. It sits between a host or controller and the combinational ALU.

Parameters:
OP_W, 8, operand width
CMD_W, 4, command width
RES_W, 16, ALU result width
SETTLE, 2, cycles alu_en is held high before capture (legal range 1..15)
DEPTH, 4, result FIFO entries (power of two, at least 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when high together with req_valid
req_op1  in  OP_W  operand 1
req_op2  in  OP_W  operand 2
req_cmd  in  CMD_W  ALU command
alu_operand_1  out  OP_W  registered drive to ALU operand_1
alu_operand_2  out  OP_W  registered drive to ALU operand_2
alu_command  out  CMD_W  registered drive to ALU command
alu_en  out  1  ALU enable
alu_out  in  RES_W  ALU result
rsp_valid  out  1  FIFO non-empty
rsp_ready  in  1  consumer pops head when high together with rsp_valid
rsp_data  out  RES_W  FIFO head result (first-word fall-through)
rsp_cmd  out  CMD_W  command that produced rsp_data
busy  out  1  high while in EXEC
fifo_count  out  log2(DEPTH)+1  entries held

Behaviour:
- Reset (async, rst=1): state IDLE; alu_operand_1, alu_operand_2 and alu_command are 0; alu_en=0; FIFO emptied; rsp_valid=0; rsp_data=0; rsp_cmd=0; busy=0; fifo_count=0; settle counter 0.
- FSM has two states, IDLE and EXEC.
- IDLE: req_ready = (fifo_count < DEPTH). alu_en=0. The alu_* operand and command outputs hold their last values.
- Accept in cycle N (req_valid && req_ready): at that edge, load alu_operand_1, alu_operand_2 and alu_command from the request, set alu_en=1, load the settle counter with SETTLE-1, and go to EXEC.
- EXEC: req_ready=0, busy=1, alu_en=1, alu_* inputs stable. The counter decrements each cycle.
- At the last EXEC cycle (counter==0, cycle N+SETTLE): sample alu_out and alu_command at the edge, push {result, cmd} into the FIFO, clear alu_en and go to IDLE.
- Timing: the result is visible on rsp_data in cycle N+SETTLE+1 if the FIFO was empty. req_ready may be high again in cycle N+SETTLE+1. Throughput is one command per SETTLE+1 cycles.
- Push while full cannot occur, because space is reserved by the accept condition and only one command is in flight.
- FIFO push and pop in the same cycle: fifo_count unchanged, order preserved.
- Pop when empty: ignored.
- Read and write pointers wrap modulo DEPTH.
- rsp_data and rsp_cmd hold the head entry while rsp_valid && !rsp_ready.
- req_* inputs are ignored outside acceptance. Changing them during EXEC has no effect.
- rst during EXEC: the in-flight command is discarded and no FIFO entry is written.
- Widths: results are captured verbatim (RES_W bits). No arithmetic is performed in this block.

Optional Feature:
Macro ALU_SEQ_DONE_COUNT_EN.
- Defined: adds output port done_count (16 bits, out). It increments by 1 on every FIFO push, wraps from 0xFFFF to 0x0000, and resets to 0. It is unaffected by pops.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Bench ALU model is used for all scenarios: cmd 0000 gives op1+op2, cmd 0010 gives op1*op2, any other cmd gives 0xDEAD; SETTLE=2.
- Reset then single request op1=30, op2=40, cmd=0000 accepted at cycle N -> alu_en high in cycles N+1..N+2; rsp_valid=1 with rsp_data=70 and rsp_cmd=0000 at cycle N+3; req_ready=1 at N+3.
- rsp_ready held 0, five back-to-back requests (cmd 0010, op1=30, op2=40) -> four results of 1200 queued; fifo_count=4; req_ready stays 0 after the fourth completes; fifth request stalls until one pop, then is accepted.
- Pop and push in the same cycle with fifo_count=2 -> count stays 2; result order matches request order.
- Assert rst in the middle of EXEC -> alu_en=0, busy=0, fifo_count=0 and rsp_valid=0 immediately; no result appears after reset release.
- Request while busy with req_valid toggling and request fields changing -> only the accepted values appear on alu_*; alu_* unchanged during EXEC.
- With ALU_SEQ_DONE_COUNT_EN: preload the counter near wrap via 3 completions after forcing 0xFFFE -> done_count reads 0xFFFF, 0x0000, 0x0001. Without the macro: the build has no done_count port.
